// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline hazard/flush controller.
package pipe_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned ADDR_W = 32;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      StRun,
      StBranchFlush,
      StMemWait
   } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: EX load whose destination feeds an operand read in ID.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   output logic             load_use
);

   always_comb begin
      load_use = ex_memread && (ex_rd != REG_ZERO) &&
                 ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller (RUN, BRANCH_FLUSH, MEM_WAIT).
// Define PIPE_CTRL_PERF_EN to build the stall_cycles/flush_events counters.
module pipe_ctrl
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_memread,
   input  logic              ex_branch_taken,
   input  logic [ADDR_W-1:0] ex_target,
   input  logic              mem_busy,
   output logic              if_stall,
   output logic              id_stall,
   output logic              ex_stall,
   output logic              mem_stall,
   output logic              id_flush,
   output logic              ex_flush,
   output logic              if_cond,
   output logic [ADDR_W-1:0] if_condNPC,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_events
);

   state_e            state_q, state_d;
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_target_q, pend_target_d;
   logic              load_use;
   logic              redirect;

   hazard_detect u_hazard_detect (
      .ex_memread (ex_memread),
      .ex_rd      (ex_rd),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_use_rs  (id_use_rs),
      .id_use_rt  (id_use_rt),
      .load_use   (load_use)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      if_stall      = 1'b0;
      id_stall      = 1'b0;
      ex_stall      = 1'b0;
      mem_stall     = 1'b0;
      id_flush      = 1'b0;
      ex_flush      = 1'b0;
      if_cond       = 1'b0;
      if_condNPC    = '0;
      redirect      = 1'b0;

      if (rst) begin
         state_d = StRun;
      end else if (mem_busy) begin
         if_stall  = 1'b1;
         id_stall  = 1'b1;
         ex_stall  = 1'b1;
         mem_stall = 1'b1;
         state_d   = StMemWait;
         if (state_q == StMemWait && ex_branch_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = ex_target;
         end
      end else if (state_q == StMemWait) begin
         state_d = StRun;
         if (pend_valid_q) begin
            redirect      = 1'b1;
            if_condNPC    = pend_target_q;
            pend_valid_d  = 1'b0;
            pend_target_d = '0;
            state_d       = StBranchFlush;
         end
      end else if (ex_branch_taken) begin
         redirect   = 1'b1;
         if_condNPC = ex_target;
         state_d    = StBranchFlush;
      end else if (state_q == StBranchFlush) begin
         id_flush = 1'b1;
         state_d  = StRun;
      end else if (load_use) begin
         // Hold IF/ID and send a bubble into EX while the load completes.
         if_stall = 1'b1;
         id_stall = 1'b1;
         ex_flush = 1'b1;
      end

      if (redirect) begin
         if_cond  = 1'b1;
         id_flush = 1'b1;
         ex_flush = 1'b1;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (if_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = rst ? 32'd0 : stall_cnt_q;
   assign flush_events = rst ? 32'd0 : flush_cnt_q;
`else
   logic unused_redirect;
   assign unused_redirect = redirect;
   assign stall_cycles    = 32'd0;
   assign flush_events    = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        id_use_rs, id_use_rt, ex_memread, ex_branch_taken, mem_busy;
   logic [31:0] ex_target;
   logic        if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, if_cond;
   logic [31:0] if_condNPC, stall_cycles, flush_events;

   int checks   = 0;
   int failures = 0;

`ifdef PIPE_CTRL_PERF_EN
   localparam logic [31:0] PerfExp = 32'd1;
`else
   localparam logic [31:0] PerfExp = 32'd0;
`endif

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_use_rs       (id_use_rs),
      .id_use_rt       (id_use_rt),
      .ex_rd           (ex_rd),
      .ex_memread      (ex_memread),
      .ex_branch_taken (ex_branch_taken),
      .ex_target       (ex_target),
      .mem_busy        (mem_busy),
      .if_stall        (if_stall),
      .id_stall        (id_stall),
      .ex_stall        (ex_stall),
      .mem_stall       (mem_stall),
      .id_flush        (id_flush),
      .ex_flush        (ex_flush),
      .if_cond         (if_cond),
      .if_condNPC      (if_condNPC),
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events)
   );

   // Order: if_stall id_stall ex_stall mem_stall id_flush ex_flush if_cond
   function automatic logic [6:0] ctl();
      return {if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, if_cond};
   endfunction

   task automatic clear_inputs();
      id_rs = '0; id_rt = '0; ex_rd = '0;
      id_use_rs = 1'b0; id_use_rt = 1'b0; ex_memread = 1'b0;
      ex_branch_taken = 1'b0; ex_target = '0; mem_busy = 1'b0;
   endtask

   // Advance one cycle; inputs are driven 1ns after the edge, sampled at +2ns.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      mem_busy = 1'b1; ex_branch_taken = 1'b1; ex_target = 32'h44;
      ex_memread = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
      tick();
      #1;
      checks++;
      if (ctl() !== 7'b0 || if_condNPC !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got ctl=%b npc=%h want ctl=0000000 npc=0", ctl(), if_condNPC);
      end
      checks++;
      if (stall_cycles !== 32'h0 || flush_events !== 32'h0) begin
         failures++;
         $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, flush_events);
      end
      tick();
      rst = 1'b0;
      clear_inputs();
      #1;
      checks++;
      if (ctl() !== 7'b0) begin
         failures++;
         $display("FAIL reset_idle got ctl=%b want 0000000", ctl());
      end
      tick();
   endtask

   task automatic test_load_use();
      ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
      #1;
      checks++;
      if (ctl() !== 7'b1100010) begin
         failures++;
         $display("FAIL load_use_rs got ctl=%b want 1100010", ctl());
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if (ctl() !== 7'b0) begin
         failures++;
         $display("FAIL load_use_release got ctl=%b want 0000000", ctl());
      end
      tick();
      ex_memread = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1; id_rs = 5'd1;
      id_use_rs = 1'b1;
      #1;
      checks++;
      if (ctl() !== 7'b1100010) begin
         failures++;
         $display("FAIL load_use_rt got ctl=%b want 1100010", ctl());
      end
      tick();
      id_use_rt = 1'b0;
      #1;
      checks++;
      if (ctl() !== 7'b0) begin
         failures++;
         $display("FAIL load_use_rt_unused got ctl=%b want 0000000", ctl());
      end
      tick();
      ex_memread = 1'b0; id_use_rt = 1'b1;
      #1;
      checks++;
      if (ctl() !== 7'b0) begin
         failures++;
         $display("FAIL no_load_no_stall got ctl=%b want 0000000", ctl());
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_rd_zero();
      ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
      id_rt = 5'd0; id_use_rt = 1'b1;
      #1;
      checks++;
      if (ctl() !== 7'b0) begin
         failures++;
         $display("FAIL rd_zero got ctl=%b want 0000000", ctl());
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_branch();
      ex_branch_taken = 1'b1; ex_target = 32'h10;
      #1;
      checks++;
      if (ctl() !== 7'b0000111 || if_condNPC !== 32'h10) begin
         failures++;
         $display("FAIL branch_redirect got ctl=%b npc=%h want 0000111 npc=00000010", ctl(),
                  if_condNPC);
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if (ctl() !== 7'b0000100 || if_condNPC !== 32'h0) begin
         failures++;
         $display("FAIL branch_flush got ctl=%b npc=%h want 0000100 npc=0", ctl(), if_condNPC);
      end
      tick();
      #1;
      checks++;
      if (ctl() !== 7'b0) begin
         failures++;
         $display("FAIL branch_idle got ctl=%b want 0000000", ctl());
      end
      tick();
   endtask

   task automatic test_back_to_back();
      // Branch plus load-use in RUN: branch wins.
      ex_branch_taken = 1'b1; ex_target = 32'h100;
      ex_memread = 1'b1; ex_rd = 5'd7; id_rs = 5'd7; id_use_rs = 1'b1;
      #1;
      checks++;
      if (ctl() !== 7'b0000111 || if_condNPC !== 32'h100) begin
         failures++;
         $display("FAIL branch_over_load got ctl=%b npc=%h want 0000111 npc=00000100", ctl(),
                  if_condNPC);
      end
      tick();
      clear_inputs();
      ex_branch_taken = 1'b1; ex_target = 32'h20;
      #1;
      checks++;
      if (ctl() !== 7'b0000111 || if_condNPC !== 32'h20) begin
         failures++;
         $display("FAIL branch_in_flush got ctl=%b npc=%h want 0000111 npc=00000020", ctl(),
                  if_condNPC);
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if (ctl() !== 7'b0000100) begin
         failures++;
         $display("FAIL branch_reflush got ctl=%b want 0000100", ctl());
      end
      tick();
   endtask

   task automatic test_mem_wait();
      logic [6:0] got [3];
      mem_busy = 1'b1;
      ex_branch_taken = 1'b1; ex_target = 32'h99;
      #1; got[0] = ctl();
      tick();
      ex_target = 32'h40;
      #1; got[1] = ctl();
      tick();
      ex_branch_taken = 1'b0;
      ex_memread = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_use_rs = 1'b1;
      #1; got[2] = ctl();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got[i] !== 7'b1111000) begin
            failures++;
            $display("FAIL mem_wait_stall[%0d] got ctl=%b want 1111000", i, got[i]);
         end
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if (ctl() !== 7'b0000111 || if_condNPC !== 32'h40) begin
         failures++;
         $display("FAIL mem_exit_redirect got ctl=%b npc=%h want 0000111 npc=00000040", ctl(),
                  if_condNPC);
      end
      tick();
      #1;
      checks++;
      if (ctl() !== 7'b0000100) begin
         failures++;
         $display("FAIL mem_exit_flush got ctl=%b want 0000100", ctl());
      end
      tick();
      mem_busy = 1'b1;
      tick();
      mem_busy = 1'b0;
      #1;
      checks++;
      if (ctl() !== 7'b0 || if_condNPC !== 32'h0) begin
         failures++;
         $display("FAIL mem_exit_no_pend got ctl=%b npc=%h want 0000000 npc=0", ctl(),
                  if_condNPC);
      end
      tick();
   endtask

   task automatic test_reset_pending();
      mem_busy = 1'b1;
      tick();
      ex_branch_taken = 1'b1; ex_target = 32'h40;
      tick();
      clear_inputs();
      rst = 1'b1;
      #1;
      checks++;
      if (ctl() !== 7'b0 || if_condNPC !== 32'h0) begin
         failures++;
         $display("FAIL rst_in_wait got ctl=%b npc=%h want 0000000 npc=0", ctl(), if_condNPC);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (ctl() !== 7'b0 || if_condNPC !== 32'h0) begin
         failures++;
         $display("FAIL rst_discard_pend got ctl=%b npc=%h want 0000000 npc=0", ctl(),
                  if_condNPC);
      end
      tick();
   endtask

   task automatic test_perf();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
      tick();
      clear_inputs();
      ex_branch_taken = 1'b1; ex_target = 32'h10;
      tick();
      clear_inputs();
      #1;
      checks++;
      if (stall_cycles !== PerfExp) begin
         failures++;
         $display("FAIL perf_stall_cycles got %0d want %0d", stall_cycles, PerfExp);
      end
      checks++;
      if (flush_events !== PerfExp) begin
         failures++;
         $display("FAIL perf_flush_events got %0d want %0d", flush_events, PerfExp);
      end
      tick();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_load_use();
      test_rd_zero();
      test_branch();
      test_back_to_back();
      test_mem_wait();
      test_reset_pending();
      test_perf();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock and one reset: clk and rst; rst is synchronous and active-high.
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 id_rs, id_rt  input  5 each  source register fields of instruction in ID.
REQ-005 id_use_rs, id_use_rt  input  1 each  ID instruction actually reads rs / rt.
REQ-006 ex_rd  input  5  destination register of instruction in EX.
REQ-007 ex_memread  input  1  EX instruction is a load.
REQ-008 ex_branch_taken  input  1  EX resolved branch/jump as taken this cycle.
REQ-009 ex_target  input  32  redirect address for taken branch/jump.
REQ-010 mem_busy  input  1  data memory not ready; MEM cannot complete this cycle.
REQ-011 if_stall, id_stall, ex_stall, mem_stall  output  1 each  hold the stage register.
REQ-012 id_flush, ex_flush  output  1 each  replace the stage register contents with a bubble on the next edge.
REQ-013 if_cond  output  1  drives IF stage cond; selects if_condNPC as next PC.
REQ-014 if_condNPC  output  32  drives IF stage condNPC.
REQ-015 stall_cycles, flush_events  output  32 each  performance counters (see Configuration).

Function
REQ-016 States SHALL be RUN, BRANCH_FLUSH and MEM_WAIT; hazard outputs are combinational from state and inputs.
REQ-017 Priority SHALL be mem_busy > ex_branch_taken > load-use hazard.
REQ-018 Load-use hazard SHALL be ex_memread && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
REQ-019 RUN, load-use, no higher event: if_stall=id_stall=ex_flush=1 that cycle only; state stays RUN.
REQ-020 RUN, ex_branch_taken, mem_busy=0: if_cond=1, if_condNPC=ex_target, id_flush=ex_flush=1 same cycle; next state BRANCH_FLUSH.
REQ-021 BRANCH_FLUSH: id_flush=1 for exactly one cycle, if_cond=0; next state RUN; a new ex_branch_taken here is handled as in REQ-020 (state re-enters BRANCH_FLUSH).
REQ-022 Any state, mem_busy=1: all four stall outputs=1, if_cond=0, no flushes; next state MEM_WAIT.
REQ-023 In MEM_WAIT a taken branch SHALL be latched (pend_valid, pend_target); load-use is ignored.
REQ-024 MEM_WAIT exit (mem_busy=0): if pend_valid, perform REQ-020 with pend_target and clear pend; else go to RUN with no redirect.
REQ-025 ex_rd==0 SHALL never raise a load-use stall.
REQ-026 Outputs not asserted by a rule SHALL be 0; if_condNPC SHALL be 0 when if_cond=0.

Reset
REQ-027 While rst=1: state=RUN, pend_valid=0, pend_target=0, counters=0, every output 0.
REQ-028 rst in MEM_WAIT or BRANCH_FLUSH SHALL discard pending redirect; first cycle after reset is RUN.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_EN defined: stall_cycles increments each cycle if_stall=1; flush_events increments on each REQ-020 redirect; both wrap at 2^32.
REQ-030 PIPE_CTRL_PERF_EN undefined: counter logic absent, stall_cycles and flush_events tied to 0; ports remain.

Structure
REQ-031 Package pipe_pkg SHALL hold state typedef, REG_W=5, ADDR_W=32, REG_ZERO=0.
REQ-032 Combinational sub-module hazard_detect SHALL implement REQ-018 and be instantiated once.

Verification
REQ-033 RUN, ex_memread=1, ex_rd=5, id_rs=5, id_use_rs=1 -> if_stall=id_stall=ex_flush=1 for one cycle, then 0.
REQ-034 ex_memread=1, ex_rd=0, id_rs=0, id_use_rs=1 -> no stall.
REQ-035 ex_branch_taken=1, ex_target=0x10 -> if_cond=1, if_condNPC=0x10, id_flush=ex_flush=1; next cycle id_flush=1 only; then idle.
REQ-036 mem_busy=1 for 3 cycles with ex_branch_taken=1, target 0x40 in cycle 2 -> stalls=1 for 3 cycles, then redirect to 0x40 on exit cycle.
REQ-037 rst=1 during MEM_WAIT with pending 0x40 -> all outputs 0, no redirect after reset.
REQ-038 PIPE_CTRL_PERF_EN defined, REQ-033 then REQ-035 -> stall_cycles=1, flush_events=1.
